// File: rtl/johnson_pkg.sv
// Shared Johnson-code types, widths and encode/decode helpers.
// Also used by the Johnson counter source design.
package johnson_pkg;

    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] STABLE_CYCLES_DEF = 25'd2000000;
    localparam int BITS_DEF = 4;
    localparam int MAX_BITS = 16;

    typedef logic [MAX_BITS-1:0] jcode_t;
    typedef logic [7:0] jidx_t;

    typedef struct packed {
        logic  legal;
        jidx_t idx;
    } jdec_t;

    typedef enum logic [1:0] {
        TRK_IDLE,
        TRK_LOCKED,
        TRK_RESYNC
    } trk_state_t;

    function automatic int idx_width(input int bits);
        return (bits < 1) ? 1 : $clog2(2 * bits);
    endfunction

    localparam int IDX_W_DEF = idx_width(BITS_DEF);

    function automatic jcode_t johnson_encode(
        input int    bits,
        input jidx_t idx
    );
        jcode_t c;
        int     n;
        c = '0;
        n = int'(idx);
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < bits) begin
                if (n <= bits) begin
                    c[i] = (i < n);
                end else begin
                    c[i] = (i >= n - bits);
                end
            end
        end
        return c;
    endfunction

    // Popcount gives the step; the MSB tells which half of the cycle we are in.
    function automatic jdec_t johnson_decode(
        input int     bits,
        input jcode_t code
    );
        jdec_t d;
        int    p;
        logic  msb;
        p   = 0;
        msb = 1'b0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < bits) begin
                p = p + int'(code[i]);
                if (i == bits - 1) begin
                    msb = code[i];
                end
            end
        end
        d.idx   = msb ? jidx_t'(2 * bits - p) : jidx_t'(p);
        d.legal = (johnson_encode(bits, d.idx) == code);
        return d;
    endfunction

endpackage

// File: rtl/johnson_rx_decoder_sync_filter.sv
// Pin synchronizer, polarity fix and stability filter for the Johnson bus.
// code_o carries the qualified sample; it is meaningful while commit_o is high.
module johnson_sync_filter
    import johnson_pkg::*;
#(
    parameter int               BITS          = 4,
    parameter logic [CNT_W-1:0] STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter bit               ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] din_i,
    output logic [BITS-1:0] code_o,
    output logic            commit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = STABLE_CYCLES - 25'd1;

    logic [BITS-1:0]  sync1_q;
    logic [BITS-1:0]  sync2_q;
    logic [BITS-1:0]  prev_q;
    logic [BITS-1:0]  code_q;
    logic [1:0]       fill_q;
    logic             prev_vld_q;
    logic             have_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [BITS-1:0]  sample;
    logic             same;
    logic             commit;

    assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign same   = prev_vld_q && (sample == prev_q);
    assign commit = same && (cnt_q == CNT_MAX)
                    && (!have_q || (sample != code_q));

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 25'd1;
        end
    end

    // fill_q keeps the reset contents of the synchronizer out of the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            fill_q     <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            cnt_q      <= '0;
            code_q     <= '0;
            have_q     <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1]) begin
                prev_q     <= sample;
                prev_vld_q <= 1'b1;
                cnt_q      <= cnt_d;
            end
            if (commit) begin
                code_q <= sample;
                have_q <= 1'b1;
            end
        end
    end

    assign code_o   = sample;
    assign commit_o = commit;

endmodule

// File: rtl/johnson_rx_decoder.sv
// Johnson bus receiver: decode, step direction, position count
// and sticky error flags on top of the stability filter.
module johnson_rx_decoder
    import johnson_pkg::*;
#(
    parameter int               BITS          = 4,
    parameter logic [CNT_W-1:0] STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int               POS_W         = 8,
    parameter bit               ACTIVE_LOW    = 1'b1,
    localparam int              IDX_W         = idx_width(BITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BITS-1:0]         johnson_in,
    input  logic                    clear_err,
    output logic [IDX_W-1:0]        index,
    output logic                    valid,
    output logic                    step_fwd,
    output logic                    step_bwd,
    output logic signed [POS_W-1:0] position,
    output logic                    illegal,
    output logic                    skip
);

    localparam int SEQ = 2 * BITS;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ - 1);

    logic [BITS-1:0] cand;
    logic            commit;
    jcode_t          code_ext;
    jdec_t           dec;
    logic            legal;
    logic [IDX_W-1:0] new_idx;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;

    trk_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                   fwd_q, fwd_d;
    logic                   bwd_q, bwd_d;
    logic                   ill_q, ill_d;
    logic                   skip_q, skip_d;

    johnson_sync_filter #(
        .BITS          (BITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_filter (
        .clk      (clk),
        .rst_n    (reset),
        .din_i    (johnson_in),
        .code_o   (cand),
        .commit_o (commit)
    );

    always_comb begin
        code_ext            = '0;
        code_ext[BITS-1:0]  = cand;
    end

    assign dec     = johnson_decode(BITS, code_ext);
    assign legal   = dec.legal && (dec.idx < jidx_t'(SEQ));
    assign new_idx = dec.idx[IDX_W-1:0];
    assign idx_inc = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    assign idx_dec = (idx_q == '0) ? LAST : idx_q - 1'b1;

    // Clear is applied first so a coinciding set event wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        fwd_d   = 1'b0;
        bwd_d   = 1'b0;
        ill_d   = clear_err ? 1'b0 : ill_q;
        skip_d  = clear_err ? 1'b0 : skip_q;
        if (commit) begin
            priority case (1'b1)
                !legal: begin
                    ill_d = 1'b1;
                    if (state_q == TRK_LOCKED) begin
                        state_d = TRK_RESYNC;
                    end
                end
                state_q != TRK_LOCKED: begin
                    idx_d   = new_idx;
                    state_d = TRK_LOCKED;
                end
                new_idx == idx_inc: begin
                    idx_d = new_idx;
                    fwd_d = 1'b1;
                    pos_d = pos_q + POS_W'(1);
                end
                new_idx == idx_dec: begin
                    idx_d = new_idx;
                    bwd_d = 1'b1;
                    pos_d = pos_q - POS_W'(1);
                end
                default: begin
                    idx_d  = new_idx;
                    skip_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TRK_IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            fwd_q   <= 1'b0;
            bwd_q   <= 1'b0;
            ill_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            fwd_q   <= fwd_d;
            bwd_q   <= bwd_d;
            ill_q   <= ill_d;
            skip_q  <= skip_d;
        end
    end

    assign index    = idx_q;
    assign valid    = (state_q != TRK_IDLE);
    assign step_fwd = fwd_q;
    assign step_bwd = bwd_q;
    assign position = pos_q;
    assign illegal  = ill_q;
    assign skip     = skip_q;

endmodule

// File: tb/tb_johnson_rx_decoder.sv
// Directed scoreboard bench for johnson_rx_decoder
// (BITS=4, STABLE_CYCLES=4, ACTIVE_LOW=1).
module tb_johnson_rx_decoder;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear_err = 1'b0;
    logic [3:0]        johnson_in = 4'hF;
    logic [2:0]        index;
    logic              valid;
    logic              step_fwd;
    logic              step_bwd;
    logic signed [7:0] position;
    logic              illegal;
    logic              skip;

    johnson_rx_decoder #(
        .BITS          (4),
        .STABLE_CYCLES (25'd4),
        .POS_W         (8),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .johnson_in (johnson_in),
        .clear_err  (clear_err),
        .index      (index),
        .valid      (valid),
        .step_fwd   (step_fwd),
        .step_bwd   (step_bwd),
        .position   (position),
        .illegal    (illegal),
        .skip       (skip)
    );

    always #10 clk = ~clk;

    typedef struct {
        string             tag;
        int                idx;
        logic              vld;
        logic signed [7:0] pos;
        logic              ill;
        logic              skp;
        int                nf;
        int                nb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   nfwd = 0;
    int   nbwd = 0;

    logic [3:0] tbl [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

    int                m_idx;
    logic              m_vld;
    logic signed [7:0] m_pos;
    logic              m_ill;
    logic              m_skp;
    logic              m_resync;
    logic              m_have;
    logic [3:0]        m_code;

    always @(negedge clk) begin
        if (step_fwd === 1'b1) nfwd = nfwd + 1;
        if (step_bwd === 1'b1) nbwd = nbwd + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_vld = 0; m_pos = 0; m_ill = 0; m_skp = 0;
        m_resync = 0; m_have = 0; m_code = 4'b0000;
    endtask

    task automatic model(input logic [3:0] c, output int ef, output int eb);
        int f;
        f = -1; ef = 0; eb = 0;
        for (int i = 0; i < 8; i++) if (tbl[i] == c) f = i;
        if (m_have && c == m_code) return;
        m_have = 1; m_code = c;
        if (f < 0) begin
            m_ill = 1;
            if (m_vld) m_resync = 1;
        end else if (!m_vld || m_resync) begin
            m_idx = f; m_vld = 1; m_resync = 0;
        end else if (f == (m_idx + 1) % 8) begin
            ef = 1; m_pos = m_pos + 8'sd1; m_idx = f;
        end else if (f == (m_idx + 7) % 8) begin
            eb = 1; m_pos = m_pos - 8'sd1; m_idx = f;
        end else begin
            m_skp = 1; m_idx = f;
        end
    endtask

    task automatic push_exp(input string tag, input int ef, input int eb);
        exp_t e;
        e.tag = tag; e.idx = m_idx; e.vld = m_vld; e.pos = m_pos;
        e.ill = m_ill; e.skp = m_skp; e.nf = ef; e.nb = eb;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int af, input int ab);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".index"}, 32'(index), e.idx);
        chk({e.tag, ".valid"}, 32'(valid), 32'(e.vld));
        chk({e.tag, ".position"}, 32'(position), 32'(e.pos));
        chk({e.tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        chk({e.tag, ".skip"}, 32'(skip), 32'(e.skp));
        chk({e.tag, ".fwd_pulses"}, af, e.nf);
        chk({e.tag, ".bwd_pulses"}, ab, e.nb);
    endtask

    task automatic drive(input string tag, input logic [3:0] c, input int hold);
        int f0, b0, ef, eb;
        f0 = nfwd; b0 = nbwd;
        johnson_in = ~c;
        model(c, ef, eb);
        push_exp(tag, ef, eb);
        tick(hold);
        pop_check(nfwd - f0, nbwd - b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".index"}, 32'(index), 0);
        chk({tag, ".valid"}, 32'(valid), 0);
        chk({tag, ".step_fwd"}, 32'(step_fwd), 0);
        chk({tag, ".step_bwd"}, 32'(step_bwd), 0);
        chk({tag, ".position"}, 32'(position), 0);
        chk({tag, ".illegal"}, 32'(illegal), 0);
        chk({tag, ".skip"}, 32'(skip), 0);
    endtask

    initial begin
        int f0, b0, ef, eb;
        model_reset();
        johnson_in = ~4'b0000;
        tick(3);
        chk_all_zero("reset");

        f0 = nfwd; b0 = nbwd;
        model(4'b0000, ef, eb);
        push_exp("first", ef, eb);
        reset = 1'b1;
        tick(6);
        chk("latency_edge6.valid", 32'(valid), 0);
        tick(1);
        chk("latency_edge7.valid", 32'(valid), 1);
        tick(3);
        pop_check(nfwd - f0, nbwd - b0);

        for (int i = 1; i <= 8; i++) drive("fwd", tbl[i % 8], 10);

        johnson_in = ~4'b0001;
        tick(3);
        drive("glitch", 4'b0000, 10);

        drive("bwd7", 4'b1000, 10);
        drive("bwd6", 4'b1100, 10);

        drive("illegal", 4'b0101, 10);
        drive("resync", 4'b0011, 10);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        m_ill = 0; m_skp = 0;
        chk("clear.illegal", 32'(illegal), 32'(m_ill));
        chk("clear.skip", 32'(skip), 32'(m_skp));

        drive("bwd1", 4'b0001, 10);
        drive("bwd0", 4'b0000, 10);
        drive("skip", 4'b0111, 10);

        f0 = nfwd; b0 = nbwd;
        johnson_in = ~4'b1010;
        m_ill = 0; m_skp = 0;
        model(4'b1010, ef, eb);
        push_exp("set_beats_clear", ef, eb);
        tick(6);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        tick(3);
        pop_check(nfwd - f0, nbwd - b0);
        drive("resync4", 4'b1111, 10);

        johnson_in = ~4'b0000;
        tick(3);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        tick(2);
        reset = 1'b1;
        drive("requalify", 4'b0000, 10);

        for (int i = 1; i <= 128; i++) drive("wrap", tbl[i % 8], 8);
        chk("wrap.position", 32'(position), -128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
